// File: rtl/regbank_pkg.sv
// Shared constants and state encoding for the 32-entry register storage array.
package regbank_pkg;
  localparam int             NUM_REGS   = 32;
  localparam int             REG_ADDR_W = 5;
  localparam logic [4:0]     ZERO_REG   = 5'd31;
  localparam logic [4:0]     LAST_CLR   = 5'd30;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/reg_bank_if.sv
// Write/clear request bus and bit-sliced read-out of the register storage array.
interface reg_bank_if #(parameter int WIDTH = 64);
  logic                                       wr_en;
  logic [regbank_pkg::REG_ADDR_W-1:0]         wr_addr;
  logic [WIDTH-1:0]                           wr_data;
  logic                                       clr_req;
  logic                                       busy;
  logic                                       wr_drop;
  logic [WIDTH-1:0][regbank_pkg::NUM_REGS-1:0] bit_slices;
  logic                                       par_err;

  modport master (
    output wr_en, wr_addr, wr_data, clr_req,
    input  busy, wr_drop, bit_slices, par_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, clr_req,
    output busy, wr_drop, bit_slices, par_err
  );
endinterface

// File: rtl/reg_bank_register_n.sv
// WIDTH-bit storage register with load enable and asynchronous active-high reset.
module register_n #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/reg_bank.sv
// 32 x WIDTH register storage with write decoder, bulk-clear FSM and bit-sliced output.
// Optional stored even parity with sticky error flag when REGBANK_PARITY_EN is defined.
module reg_bank
  import regbank_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic     clk,
  input  logic     reset,
  reg_bank_if.slave bus
);
  localparam int NSTORE = NUM_REGS - 1;

  state_e                  r_state;
  logic [REG_ADDR_W-1:0]   r_cnt;
  logic                    r_wr_drop;

  logic                    w_idle;
  logic                    w_wr_ok;
  logic [WIDTH-1:0]        w_d;
  logic [NSTORE-1:0]       w_ld;
  logic [WIDTH-1:0]        w_q [NSTORE];
  logic [WIDTH-1:0][NUM_REGS-1:0] w_slices;

  assign w_idle  = (r_state == IDLE);
  assign w_wr_ok = w_idle && bus.wr_en && (bus.wr_addr != ZERO_REG);
  // The clear sequence shares the load path; its data is simply zero.
  assign w_d     = w_idle ? bus.wr_data : '0;

  for (genvar i = 0; i < NSTORE; i++) begin : g_reg
    assign w_ld[i] = (w_wr_ok && (bus.wr_addr == REG_ADDR_W'(i))) ||
                     (!w_idle && (r_cnt == REG_ADDR_W'(i)));

    register_n #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .i_ld  (w_ld[i]),
      .i_d   (w_d),
      .o_q   (w_q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= !w_idle && bus.wr_en && (bus.wr_addr != ZERO_REG);
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.clr_req) r_state <= CLEAR;
        end
        CLEAR: begin
          if (r_cnt == LAST_CLR) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Transpose: slice j gathers bit j of every register; register 31 reads as zero.
  always_comb begin
    w_slices = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < NSTORE; i++) begin
        w_slices[j][i] = w_q[i][j];
      end
    end
  end

  assign bus.bit_slices = w_slices;
  assign bus.busy       = (r_state == CLEAR);
  assign bus.wr_drop    = r_wr_drop;

`ifdef REGBANK_PARITY_EN
  logic [NSTORE-1:0] r_par;
  logic [NSTORE-1:0] w_mis;
  logic              r_par_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_par <= '0;
    end else begin
      for (int i = 0; i < NSTORE; i++) begin
        if (w_ld[i]) r_par[i] <= w_idle ? (^bus.wr_data) : 1'b0;
      end
    end
  end

  always_comb begin
    w_mis = '0;
    for (int i = 0; i < NSTORE; i++) begin
      w_mis[i] = (^w_q[i]) ^ r_par[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_par_err <= 1'b0;
    else if (|w_mis) r_par_err <= 1'b1;
  end

  assign bus.par_err = r_par_err;
`else
  assign bus.par_err = 1'b0;
`endif
endmodule

// File: tb/tb_reg_bank.sv
// Directed testbench for reg_bank: writes, zero register, bulk clear, drops, mid-clear reset.
module tb_reg_bank;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  logic [63:0] model [32];

  reg_bank_if #(.WIDTH(64)) bus ();

  reg_bank #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] get_reg(input int i);
    logic [63:0] r;
    for (int j = 0; j < 64; j++) r[j] = bus.bit_slices[j][i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s_r%0d", tag, i), get_reg(i), model[i]);
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
    if (a != 5'd31) model[a] = d;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.clr_req = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_drop", 64'(bus.wr_drop), 64'd0);
    chk("rst_par", 64'(bus.par_err), 64'd0);
    chk_all("rst");
    reset = 1'b0;
    tick();

    // Basic write
    wr(5'd5, 64'hDEAD_BEEF_0123_4567);
    chk("wr5_direct", get_reg(5), 64'hDEAD_BEEF_0123_4567);
    chk_all("wr5");

    // Zero register
    wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("zero_r31", get_reg(31), 64'd0);
    chk("zero_drop", 64'(bus.wr_drop), 64'd0);
    chk_all("zero");

    // Fill with index
    for (int i = 0; i < 31; i++) wr(5'(i), 64'(i));
    chk_all("fill");

    // clr_req together with write to reg 2: write lands, clear starts
    bus.clr_req = 1'b1;
    wr(5'd2, 64'h0000_0000_0000_AAAA);
    bus.clr_req = 1'b0;
    chk("clr_r2_written", get_reg(2), 64'h0000_0000_0000_AAAA);
    for (int c = 0; c < 31; c++) begin
      chk($sformatf("clr_busy_c%0d", c), 64'(bus.busy), 64'd1);
      if (c == 10) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 64'h1234_5678_9ABC_DEF0;
      end else if (c == 11) begin
        bus.wr_addr = 5'd4;
      end else if (c == 12) begin
        bus.wr_en = 1'b0;
      end
      tick();
      if (c == 10 || c == 11) chk($sformatf("clr_drop_c%0d", c), 64'(bus.wr_drop), 64'd1);
      if (c == 12) chk("clr_drop_end", 64'(bus.wr_drop), 64'd0);
    end
    chk("clr_busy_done", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    chk_all("clr");

    // First non-busy cycle write
    wr(5'd7, 64'd7);
    chk("post_clr_drop", 64'(bus.wr_drop), 64'd0);
    chk_all("post_clr");

    // Mid-clear reset
    wr(5'd0, 64'h11);
    wr(5'd20, 64'h22);
    wr(5'd25, 64'h33);
    chk_all("pre_mid");
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (15) tick();
    chk("mid_busy", 64'(bus.busy), 64'd1);
    chk("mid_r0_cleared", get_reg(0), 64'd0);
    chk("mid_r25_kept", get_reg(25), 64'h33);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    for (int i = 0; i < 32; i++) model[i] = '0;
    chk_all("mid_rst");
    tick();
    reset = 1'b0;
    tick();
    wr(5'd20, 64'hCAFE_F00D_0000_0014);
    chk("after_rst_busy", 64'(bus.busy), 64'd0);
    chk_all("after_rst");

`ifdef REGBANK_PARITY_EN
    wr(5'd9, 64'h0000_0000_0000_00F1);
    chk("par_clean", 64'(bus.par_err), 64'd0);
    force dut.g_reg[9].u_reg.r_q[0] = 1'b0;
    tick();
    chk("par_set", 64'(bus.par_err), 64'd1);
    release dut.g_reg[9].u_reg.r_q[0];
    wr(5'd9, 64'h0000_0000_0000_00F1);
    tick();
    chk("par_sticky", 64'(bus.par_err), 64'd1);
    reset = 1'b1;
    #1;
    chk("par_rst", 64'(bus.par_err), 64'd0);
    tick();
    reset = 1'b0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
